branch_target_buffer: RTL and testbench

- Direct-mapped branch target buffer (BTB) in the fetch front end.
- Sits directly upstream of the bimodal direction predictor and supplies its per-lane `btbHit`; the fetch stage also takes the predicted target from here.
- Lookup uses the same `predNextPC` as the PHT with the same one-cycle read latency, so hit and counter arrive together.
- Taken branches resolved in IntEx install or refresh entries through a single write port, behind a small in-order update queue.

---
 rtl/branch_target_buffer_pkg.sv | 42 ++++
 rtl/btb_update_queue.sv | 53 +++++
 rtl/branch_target_buffer.sv | 184 ++++++++++++++++++
 tb/tb_branch_target_buffer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_target_buffer_pkg.sv
// Shared types and address helpers for the direct-mapped branch target buffer.
package BtbTypes;

  localparam int unsigned BTB_ENTRY_NUM  = 1024;
  localparam int unsigned BTB_TAG_W      = 12;
  localparam int unsigned BTB_PC_W       = 32;
  localparam int unsigned BTB_QUEUE_SIZE = 4;
  localparam int unsigned BTB_IDX_W      = $clog2(BTB_ENTRY_NUM);

  typedef logic [BTB_IDX_W-1:0] BTB_IndexPath;
  typedef logic [BTB_TAG_W-1:0] BTB_TagPath;

  typedef struct packed {
    logic                valid;
    BTB_TagPath          tag;
    logic [BTB_PC_W-3:0] target;
  } BTB_EntryPath;

  typedef struct packed {
    BTB_IndexPath        idx;
    BTB_TagPath          tag;
    logic [BTB_PC_W-3:0] target;
  } BtbQueueEntry;

  typedef logic [$clog2(BTB_QUEUE_SIZE):0] BtbQueuePointerPath;

  typedef enum logic {
    BTB_INIT,
    BTB_RUN
  } BtbPhase;

  // Width-generic helpers: callers pass the PC zero-extended and narrow the result.
  function automatic logic [63:0] ToBTB_Index(input logic [63:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] ToBTB_Tag(input logic [63:0] pc, input int unsigned idx_w,
                                            input int unsigned tag_w);
    return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
  endfunction

endpackage

// File: rtl/btb_update_queue.sv
// Multi-push, single-pop circular FIFO holding pending BTB writes in program order.
module btb_update_queue #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PUSH_N = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [PUSH_N-1:0]              push_i,
  input  logic [PUSH_N-1:0][DATA_W-1:0]  push_data_i,
  input  logic                           pop_i,
  output logic [DATA_W-1:0]              head_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH):0]         free_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic [AW-1:0]     slot [PUSH_N];

  // Pushes are compacted: the k-th asserted push lands at tail+k.
  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    empty_o  = (count == '0);
    free_o   = (AW+1)'(DEPTH) - count;
    head_o   = mem_q[rd_ptr_q[AW-1:0]];
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_i};
    wr_ptr_d = wr_ptr_q;
    for (int unsigned i = 0; i < PUSH_N; i++) begin
      slot[i] = wr_ptr_d[AW-1:0];
      if (push_i[i]) wr_ptr_d = wr_ptr_d + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < PUSH_N; i++) begin
      if (push_i[i]) mem_q[slot[i]] <= push_data_i[i];
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: multi-lane registered lookup, one array write per cycle fed by
// an in-order update queue, and a power-up invalidation sweep.
module branch_target_buffer
  import BtbTypes::*;
#(
  parameter int unsigned ENTRY_NUM   = 1024,
  parameter int unsigned TAG_W       = 12,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned UPD_WIDTH   = 2,
  parameter int unsigned QUEUE_SIZE  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] predNextPC,
  output logic            btbHit    [FETCH_WIDTH],
  output logic [PC_W-1:0] btbTarget [FETCH_WIDTH],
  input  logic            updValid  [UPD_WIDTH],
  input  logic            updTaken  [UPD_WIDTH],
  input  logic [PC_W-1:0] updPC     [UPD_WIDTH],
  input  logic [PC_W-1:0] updTarget [UPD_WIDTH],
  output logic            initDone,
  output logic            updDropped
);

  localparam int unsigned IDX_W = $clog2(ENTRY_NUM);
  localparam int unsigned TGT_W = PC_W - 2;
  localparam int unsigned ENT_W = 1 + TAG_W + TGT_W;
  localparam int unsigned QE_W  = IDX_W + TAG_W + TGT_W;
  localparam int unsigned QP_W  = $clog2(QUEUE_SIZE);

  function automatic logic [IDX_W-1:0] idx_of(input logic [PC_W-1:0] pc);
    return IDX_W'(ToBTB_Index(64'(pc), IDX_W));
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [PC_W-1:0] pc);
    return TAG_W'(ToBTB_Tag(64'(pc), IDX_W, TAG_W));
  endfunction

  BtbPhase                       state_q, state_d;
  logic [IDX_W-1:0]              sweep_q, sweep_d;
  logic                          dropped_q, dropped_d;
  logic [ENT_W-1:0]              mem_q [ENTRY_NUM];
  logic                          wr_en;
  logic [IDX_W-1:0]              wr_idx;
  logic [ENT_W-1:0]              wr_entry;
  logic [UPD_WIDTH-1:0]          cand, pend, push;
  logic [UPD_WIDTH-1:0][QE_W-1:0] qdata;
  logic                          pop, q_empty, found;
  logic [QE_W-1:0]               q_head, sel;
  logic [QP_W:0]                 q_free, budget;
  logic                          unused_tgt_lsbs;

  always_comb begin
    unused_tgt_lsbs = 1'b0;
    for (int unsigned i = 0; i < UPD_WIDTH; i++) begin
      cand[i]         = updValid[i] & updTaken[i];
      qdata[i]        = {idx_of(updPC[i]), tag_of(updPC[i]), updTarget[i][PC_W-1:2]};
      unused_tgt_lsbs = unused_tgt_lsbs ^ (^updTarget[i][1:0]);
    end
  end

  btb_update_queue #(
    .DATA_W (QE_W),
    .DEPTH  (QUEUE_SIZE),
    .PUSH_N (UPD_WIDTH)
  ) u_queue (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (push),
    .push_data_i (qdata),
    .pop_i       (pop),
    .head_o      (q_head),
    .empty_o     (q_empty),
    .free_o      (q_free)
  );

  // When the queue holds anything its head owns the write port, so every candidate
  // must queue behind it; otherwise the oldest candidate bypasses the queue.
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    dropped_d = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = sweep_q;
    wr_entry  = '0;
    pop       = 1'b0;
    push      = '0;
    pend      = cand;
    budget    = '0;
    found     = 1'b0;
    sel       = q_head;
    if (state_q == BTB_INIT) begin
      wr_en   = 1'b1;
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == IDX_W'(ENTRY_NUM - 1)) state_d = BTB_RUN;
    end else begin
      if (!q_empty) begin
        pop    = 1'b1;
        found  = 1'b1;
        budget = q_free + 1'b1;
      end else begin
        budget = q_free;
        for (int unsigned i = 0; i < UPD_WIDTH; i++) begin
          if (pend[i] && !found) begin
            found   = 1'b1;
            sel     = qdata[i];
            pend[i] = 1'b0;
          end
        end
      end
      for (int unsigned i = 0; i < UPD_WIDTH; i++) begin
        if (pend[i]) begin
          if (budget != '0) begin
            push[i] = 1'b1;
            budget  = budget - 1'b1;
          end else begin
            dropped_d = 1'b1;
          end
        end
      end
      wr_en    = found;
      wr_idx   = sel[QE_W-1 -: IDX_W];
      wr_entry = {1'b1, sel[TAG_W+TGT_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= BTB_INIT;
      sweep_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      dropped_q <= dropped_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en) mem_q[wr_idx] <= wr_entry;
  end

  logic [IDX_W-1:0] lk_idx   [FETCH_WIDTH];
  logic [TAG_W-1:0] lk_tag   [FETCH_WIDTH];
  logic [ENT_W-1:0] rd_q     [FETCH_WIDTH];
  logic [TAG_W-1:0] rd_tag_q [FETCH_WIDTH];
  logic             run_q;

  always_comb begin
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      lk_idx[i] = idx_of(predNextPC + PC_W'(i * 4));
      lk_tag[i] = tag_of(predNextPC + PC_W'(i * 4));
    end
  end

  // Nonblocking array writes make same-edge read/write return the old entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q <= 1'b0;
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
        rd_q[i]     <= '0;
        rd_tag_q[i] <= '0;
      end
    end else begin
      run_q <= (state_q == BTB_RUN);
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
        rd_q[i]     <= mem_q[lk_idx[i]];
        rd_tag_q[i] <= lk_tag[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      btbHit[i]    = run_q && rd_q[i][ENT_W-1] && (rd_q[i][TAG_W+TGT_W-1:TGT_W] == rd_tag_q[i]);
      btbTarget[i] = {rd_q[i][TGT_W-1:0], 2'b00};
    end
  end

  assign initDone   = (state_q == BTB_RUN);
  assign updDropped = dropped_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer against a queue/array reference model.
module tb_branch_target_buffer;

  localparam int unsigned EN = 1024;
  localparam int unsigned QS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] predNextPC;
  logic        btbHit    [2];
  logic [31:0] btbTarget [2];
  logic        updValid  [2];
  logic        updTaken  [2];
  logic [31:0] updPC     [2];
  logic [31:0] updTarget [2];
  logic        initDone, updDropped;

  always #5 clk = ~clk;

  branch_target_buffer #(
    .ENTRY_NUM   (EN),
    .TAG_W       (12),
    .PC_W        (32),
    .FETCH_WIDTH (2),
    .UPD_WIDTH   (2),
    .QUEUE_SIZE  (QS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .predNextPC (predNextPC),
    .btbHit     (btbHit),
    .btbTarget  (btbTarget),
    .updValid   (updValid),
    .updTaken   (updTaken),
    .updPC      (updPC),
    .updTarget  (updTarget),
    .initDone   (initDone),
    .updDropped (updDropped)
  );

  typedef struct packed {
    logic [1:0]       hit;
    logic [1:0]       tchk;
    logic [1:0][31:0] tgt;
    logic             init;
    logic             drop;
  } exp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
  } upd_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: plain arrays for the table, a queue for pending writes.
  bit          m_run;
  int unsigned m_sweep;
  bit          m_drop;
  bit          m_valid [EN];
  int unsigned m_tag   [EN];
  logic [31:0] m_tgt   [EN];
  upd_t        m_q[$];

  function automatic int unsigned f_idx(input logic [31:0] pc);
    return (pc / 4) % EN;
  endfunction

  function automatic int unsigned f_tag(input logic [31:0] pc);
    return (pc / (4 * EN)) % 4096;
  endfunction

  function automatic void model_write(input upd_t u);
    m_valid[f_idx(u.pc)] = 1'b1;
    m_tag[f_idx(u.pc)]   = f_tag(u.pc);
    m_tgt[f_idx(u.pc)]   = {u.tgt[31:2], 2'b00};
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic step(input bit r, input logic [31:0] pc,
                      input bit v0, input bit t0, input logic [31:0] p0, input logic [31:0] g0,
                      input bit v1, input bit t1, input logic [31:0] p1, input logic [31:0] g1);
    exp_t e;
    upd_t c[$];
    logic [31:0] lpc;
    @(negedge clk);
    rst = r; predNextPC = pc;
    updValid[0] = v0; updTaken[0] = t0; updPC[0] = p0; updTarget[0] = g0;
    updValid[1] = v1; updTaken[1] = t1; updPC[1] = p1; updTarget[1] = g1;
    e = '0;
    for (int l = 0; l < 2; l++) begin
      lpc = pc + 32'(4 * l);
      if (!r) begin
        e.tchk[l] = 1'b1;
      end else if (m_run && m_valid[f_idx(lpc)] && m_tag[f_idx(lpc)] == f_tag(lpc)) begin
        e.hit[l]  = 1'b1;
        e.tchk[l] = 1'b1;
        e.tgt[l]  = m_tgt[f_idx(lpc)];
      end
    end
    if (!r) begin
      m_run = 0; m_sweep = 0; m_drop = 0; m_q.delete();
    end else if (!m_run) begin
      m_valid[m_sweep] = 1'b0;
      m_sweep++;
      if (m_sweep == EN) m_run = 1;
      m_drop = 0;
    end else begin
      if (v0 && t0) c.push_back('{pc: p0, tgt: g0});
      if (v1 && t1) c.push_back('{pc: p1, tgt: g1});
      if (m_q.size() > 0) model_write(m_q.pop_front());
      else if (c.size() > 0) model_write(c.pop_front());
      foreach (c[k]) m_q.push_back(c[k]);
      m_drop = 0;
      while (m_q.size() > QS) begin
        void'(m_q.pop_back());
        m_drop = 1;
      end
    end
    e.init = m_run;
    e.drop = m_drop;
    sb.push_back(e);
  endtask

  task automatic idle(input bit r, input logic [31:0] pc);
    step(r, pc, 0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  function automatic logic [31:0] pool_pc();
    return 32'(($urandom_range(0, 2) * EN * 4) + (('h40 + $urandom_range(0, 7)) * 4));
  endfunction

  // Monitor: every edge after stimulus produces one registered response.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      for (int l = 0; l < 2; l++) begin
        chk($sformatf("hit%0d", l), 32'(btbHit[l]), 32'(e.hit[l]));
        if (e.tchk[l]) chk($sformatf("target%0d", l), btbTarget[l], e.tgt[l]);
      end
      chk("initDone", 32'(initDone), 32'(e.init));
      chk("updDropped", 32'(updDropped), 32'(e.drop));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pa, pb;
    rst = 1'b0; predNextPC = '0;
    for (int i = 0; i < 2; i++) begin
      updValid[i] = 0; updTaken[i] = 0; updPC[i] = '0; updTarget[i] = '0;
    end
    m_run = 0; m_sweep = 0; m_drop = 0;
    for (int i = 0; i < int'(EN); i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0;
    end

    repeat (3) idle(0, 32'h100);
    for (int i = 0; i < int'(EN); i++)
      step(1, 32'h100, 1, 1, pool_pc(), $urandom, 1, 1, 32'h100, $urandom);

    // Install and hit, then same-index different-tag miss.
    step(1, 32'h1000, 1, 1, 32'h1000, 32'h2000, 0, 0, '0, '0);
    repeat (3) idle(1, 32'h1000);
    repeat (2) idle(1, 32'h1000 + EN * 4);

    // Same index in both slots: slot 1 lands last.
    step(1, 32'h1000, 1, 1, 32'h1000, 32'h2000, 1, 1, 32'h1000, 32'h3000);
    repeat (4) idle(1, 32'h1000);

    // Overflow: sustained two taken updates per cycle.
    for (int k = 0; k < 7; k++)
      step(1, 32'h1000, 1, 1, 32'h8000 + 32'(16 * k), $urandom, 1, 1, 32'h8008 + 32'(16 * k), $urandom);
    repeat (6) idle(1, 32'h100);
    for (int k = 0; k < 7; k++) begin
      idle(1, 32'h8000 + 32'(16 * k));
      idle(1, 32'h8008 + 32'(16 * k));
    end

    // Randomized traffic over a small, colliding PC pool.
    for (int i = 0; i < 500; i++) begin
      pa = pool_pc(); pb = pool_pc();
      step(1, pool_pc(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), pa, $urandom,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), pb, $urandom);
    end

    // Reset with three updates still queued.
    repeat (6) idle(1, 32'h100);
    for (int k = 0; k < 3; k++)
      step(1, 32'h100, 1, 1, 32'hC000 + 32'(16 * k), 32'h5000, 1, 1, 32'hC008 + 32'(16 * k), 32'h6000);
    idle(0, 32'h100);
    for (int i = 0; i < int'(EN) + 2; i++) idle(1, 32'h100);
    for (int k = 0; k < 3; k++) begin
      idle(1, 32'hC000 + 32'(16 * k));
      idle(1, 32'hC008 + 32'(16 * k));
    end
    for (int i = 0; i < 20; i++) idle(1, pool_pc());
    idle(1, 32'h1000);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
